// File: rtl/dpram_access_arbiter.sv
// Round-robin arbiter sharing the write and read ports of dual_port_ram between two requesters each.
// Optional RAW_BYPASS_EN: read data collides with a same-cycle write to the same address -> return the new data.
module dpram_access_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            wr_req,
    input  logic [2*ADDR_W-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    output logic [1:0]            wr_gnt,
    input  logic [1:0]            rd_req,
    input  logic [2*ADDR_W-1:0]   rd_addr,
    output logic [1:0]            rd_gnt,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  rd_id,
    output logic                  ram_wr,
    output logic [ADDR_W-1:0]     ram_wr_add,
    output logic [DATA_W-1:0]     ram_in,
    output logic                  ram_rd,
    output logic [ADDR_W-1:0]     ram_rd_add,
    input  logic [DATA_W-1:0]     ram_out
);

    // Pointer names the requester favoured when both are active.
    function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic ptr);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        wr_gnt_s;
    logic [1:0]        rd_gnt_s;
    logic [ADDR_W-1:0] wr_sel_add_s;
    logic [DATA_W-1:0] wr_sel_data_s;
    logic [ADDR_W-1:0] rd_sel_add_s;
    logic              ram_wr_r;
    logic [ADDR_W-1:0] ram_wr_add_r;
    logic [DATA_W-1:0] ram_in_r;
    logic              ram_rd_r;
    logic [ADDR_W-1:0] ram_rd_add_r;
    logic              rd_id_p1_r;
    logic              rd_valid_r;
    logic              rd_id_r;
    logic [DATA_W-1:0] rd_hold_r;
    logic [DATA_W-1:0] rd_src_s;
    logic [DATA_W-1:0] rd_data_s;

    // Grant decode and granted-requester payload selection.
    always_comb begin
        wr_gnt_s      = rr_grant(wr_req, wr_ptr_r);
        rd_gnt_s      = rr_grant(rd_req, rd_ptr_r);
        wr_sel_add_s  = wr_gnt_s[1] ? wr_addr[ADDR_W +: ADDR_W] : wr_addr[0 +: ADDR_W];
        wr_sel_data_s = wr_gnt_s[1] ? wr_data[DATA_W +: DATA_W] : wr_data[0 +: DATA_W];
        rd_sel_add_s  = rd_gnt_s[1] ? rd_addr[ADDR_W +: ADDR_W] : rd_addr[0 +: ADDR_W];
    end

    // Round-robin pointers: after a grant the other requester is favoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (|wr_gnt_s) wr_ptr_r <= wr_gnt_s[0];
            if (|rd_gnt_s) rd_ptr_r <= rd_gnt_s[0];
        end
    end

    // RAM-side write and read command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wr_r     <= 1'b0;
            ram_wr_add_r <= {ADDR_W{1'b0}};
            ram_in_r     <= {DATA_W{1'b0}};
            ram_rd_r     <= 1'b0;
            ram_rd_add_r <= {ADDR_W{1'b0}};
            rd_id_p1_r   <= 1'b0;
        end else begin
            ram_wr_r <= |wr_gnt_s;
            ram_rd_r <= |rd_gnt_s;
            if (|wr_gnt_s) begin
                ram_wr_add_r <= wr_sel_add_s;
                ram_in_r     <= wr_sel_data_s;
            end
            if (|rd_gnt_s) begin
                ram_rd_add_r <= rd_sel_add_s;
                rd_id_p1_r   <= rd_gnt_s[1];
            end
        end
    end

`ifdef RAW_BYPASS_EN
    logic              col_r;
    logic [DATA_W-1:0] byp_data_r;

    // Remember a same-address write/read pair so the read returns the new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r      <= 1'b0;
            byp_data_r <= {DATA_W{1'b0}};
        end else begin
            col_r      <= ram_wr_r && ram_rd_r && (ram_wr_add_r == ram_rd_add_r);
            byp_data_r <= ram_in_r;
        end
    end

    assign rd_src_s = col_r ? byp_data_r : ram_out;
`else
    assign rd_src_s = ram_out;
`endif

    // Return stage: RAM output arrives the cycle after the read is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_id_r    <= 1'b0;
            rd_hold_r  <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r <= ram_rd_r;
            if (ram_rd_r) rd_id_r <= rd_id_p1_r;
            if (rd_valid_r) rd_hold_r <= rd_src_s;
        end
    end

    // ram_out is only valid in the return cycle, so the data path is a mux against the hold register.
    always_comb begin
        rd_data_s = rd_hold_r;
        if (rd_valid_r) begin
            rd_data_s = rd_src_s;
        end else begin
            rd_data_s = rd_hold_r;
        end
    end

    assign wr_gnt     = wr_gnt_s;
    assign rd_gnt     = rd_gnt_s;
    assign ram_wr     = ram_wr_r;
    assign ram_wr_add = ram_wr_add_r;
    assign ram_in     = ram_in_r;
    assign ram_rd     = ram_rd_r;
    assign ram_rd_add = ram_rd_add_r;
    assign rd_valid   = rd_valid_r;
    assign rd_id      = rd_id_r;
    assign rd_data    = rd_data_s;

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Table-driven bench for dpram_access_arbiter with a behavioural dual_port_ram attached.
module tb_dpram_access_arbiter;
    localparam int AW = 12;
    localparam int DW = 64;
`ifdef RAW_BYPASS_EN
    localparam logic [DW-1:0] COLL = 64'h2222;
`else
    localparam logic [DW-1:0] COLL = 64'h1111;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    wr_req = 2'b00;
    logic [AW-1:0] wa0 = '0, wa1 = '0, ra0 = '0, ra1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic [1:0]    rd_req = 2'b00;
    logic [1:0]    wr_gnt, rd_gnt;
    logic [DW-1:0] rd_data, ram_in, ram_out;
    logic          rd_valid, rd_id, ram_wr, ram_rd;
    logic [AW-1:0] ram_wr_add, ram_rd_add;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    dpram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr({wa1, wa0}), .wr_data({wd1, wd0}), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr({ra1, ra0}), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id),
        .ram_wr(ram_wr), .ram_wr_add(ram_wr_add), .ram_in(ram_in),
        .ram_rd(ram_rd), .ram_rd_add(ram_rd_add), .ram_out(ram_out)
    );

    // dual_port_ram: registered read, read-before-write on collision
    always @(posedge clk) begin
        if (ram_wr) mem[ram_wr_add] <= ram_in;
        if (ram_rd) ram_out <= mem[ram_rd_add];
    end

    typedef struct {
        logic [1:0]    wr_req;
        logic [AW-1:0] wa0, wa1;
        logic [DW-1:0] wd0, wd1;
        logic [1:0]    rd_req;
        logic [AW-1:0] ra0, ra1;
        logic [1:0]    e_wgnt, e_rgnt;
        logic          e_ram_wr;
        logic [AW-1:0] e_wadd;
        logic [DW-1:0] e_win;
        logic          e_ram_rd;
        logic          e_rvalid;
        logic          e_rid;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_req = 2'b00; rd_req = 2'b00;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra0 = '0; ra1 = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " ram_wr"}, 64'(ram_wr), 64'h0);
        check({tag, " ram_rd"}, 64'(ram_rd), 64'h0);
        check({tag, " ram_wr_add"}, 64'(ram_wr_add), 64'h0);
        check({tag, " ram_rd_add"}, 64'(ram_rd_add), 64'h0);
        check({tag, " ram_in"}, ram_in, 64'h0);
        check({tag, " rd_valid"}, 64'(rd_valid), 64'h0);
        check({tag, " rd_id"}, 64'(rd_id), 64'h0);
        check({tag, " rd_data"}, rd_data, 64'h0);
    endtask

    initial begin
        //          wreq   wa0     wa1     wd0        wd1        rreq   ra0     ra1     wgnt   rgnt   rwr   wadd    win         rrd   rv    rid   rdata
        tbl[0]  = '{2'b01, 12'h005, 12'h000, 64'hA5A5, 64'h0,    2'b00, 12'h000, 12'h000, 2'b01, 2'b00, 1'b0, 12'h000, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0};
        tbl[1]  = '{2'b10, 12'h000, 12'h010, 64'h0,    64'h1234, 2'b00, 12'h000, 12'h000, 2'b10, 2'b00, 1'b1, 12'h005, 64'hA5A5, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[2]  = '{2'b11, 12'h100, 12'h101, 64'h100,  64'h101,  2'b10, 12'h000, 12'h010, 2'b01, 2'b10, 1'b1, 12'h010, 64'h1234, 1'b0, 1'b0, 1'b0, 64'h0};
        tbl[3]  = '{2'b11, 12'h102, 12'h101, 64'h102,  64'h101,  2'b00, 12'h000, 12'h000, 2'b10, 2'b00, 1'b1, 12'h100, 64'h100,  1'b1, 1'b0, 1'b0, 64'h0};
        tbl[4]  = '{2'b11, 12'h102, 12'h103, 64'h102,  64'h103,  2'b00, 12'h000, 12'h000, 2'b01, 2'b00, 1'b1, 12'h101, 64'h101,  1'b0, 1'b1, 1'b1, 64'h1234};
        tbl[5]  = '{2'b11, 12'h104, 12'h103, 64'h104,  64'h103,  2'b00, 12'h000, 12'h000, 2'b10, 2'b00, 1'b1, 12'h102, 64'h102,  1'b0, 1'b0, 1'b0, 64'h1234};
        tbl[6]  = '{2'b01, 12'h104, 12'h000, 64'h104,  64'h0,    2'b11, 12'h100, 12'h101, 2'b01, 2'b01, 1'b1, 12'h103, 64'h103,  1'b0, 1'b0, 1'b0, 64'h1234};
        tbl[7]  = '{2'b00, 12'h000, 12'h000, 64'h0,    64'h0,    2'b11, 12'h102, 12'h101, 2'b00, 2'b10, 1'b1, 12'h104, 64'h104,  1'b1, 1'b0, 1'b0, 64'h1234};
        tbl[8]  = '{2'b00, 12'h000, 12'h000, 64'h0,    64'h0,    2'b01, 12'h102, 12'h000, 2'b00, 2'b01, 1'b0, 12'h000, 64'h0,    1'b1, 1'b1, 1'b0, 64'h100};
        tbl[9]  = '{2'b01, 12'h020, 12'h000, 64'h1111, 64'h0,    2'b00, 12'h000, 12'h000, 2'b01, 2'b00, 1'b0, 12'h000, 64'h0,    1'b1, 1'b1, 1'b1, 64'h101};
        tbl[10] = '{2'b10, 12'h000, 12'h020, 64'h0,    64'h2222, 2'b10, 12'h000, 12'h020, 2'b10, 2'b10, 1'b1, 12'h020, 64'h1111, 1'b0, 1'b1, 1'b0, 64'h102};
        tbl[11] = '{2'b00, 12'h000, 12'h000, 64'h0,    64'h0,    2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b1, 12'h020, 64'h2222, 1'b1, 1'b0, 1'b0, 64'h102};
        tbl[12] = '{2'b00, 12'h000, 12'h000, 64'h0,    64'h0,    2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h000, 64'h0,    1'b0, 1'b1, 1'b1, COLL};
        tbl[13] = '{2'b00, 12'h000, 12'h000, 64'h0,    64'h0,    2'b00, 12'h000, 12'h000, 2'b00, 2'b00, 1'b0, 12'h000, 64'h0,    1'b0, 1'b0, 1'b0, COLL};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        check("reset wr_gnt", 64'(wr_gnt), 64'h0);
        check("reset rd_gnt", 64'(rd_gnt), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            wr_req = tbl[i].wr_req; wa0 = tbl[i].wa0; wa1 = tbl[i].wa1;
            wd0 = tbl[i].wd0; wd1 = tbl[i].wd1;
            rd_req = tbl[i].rd_req; ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
            #1;
            check($sformatf("row%0d wr_gnt", i), 64'(wr_gnt), 64'(tbl[i].e_wgnt));
            check($sformatf("row%0d rd_gnt", i), 64'(rd_gnt), 64'(tbl[i].e_rgnt));
            check($sformatf("row%0d ram_wr", i), 64'(ram_wr), 64'(tbl[i].e_ram_wr));
            if (tbl[i].e_ram_wr) begin
                check($sformatf("row%0d ram_wr_add", i), 64'(ram_wr_add), 64'(tbl[i].e_wadd));
                check($sformatf("row%0d ram_in", i), ram_in, tbl[i].e_win);
            end
            check($sformatf("row%0d ram_rd", i), 64'(ram_rd), 64'(tbl[i].e_ram_rd));
            check($sformatf("row%0d rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rvalid));
            if (tbl[i].e_rvalid) check($sformatf("row%0d rd_id", i), 64'(rd_id), 64'(tbl[i].e_rid));
            check($sformatf("row%0d rd_data", i), rd_data, tbl[i].e_rdata);
        end

        // Grant requester 0 on both ports so both pointers move to 1, then reset mid-flight
        @(negedge clk);
        wr_req = 2'b01; wa0 = 12'h030; wd0 = 64'h3030;
        rd_req = 2'b01; ra0 = 12'h005;
        #1;
        check("pre-reset wr_gnt", 64'(wr_gnt), 64'h1);
        check("pre-reset rd_gnt", 64'(rd_gnt), 64'h1);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("post-reset rd_valid c%0d", k), 64'(rd_valid), 64'h0);
            check($sformatf("post-reset rd_data c%0d", k), rd_data, 64'h0);
        end

        // Pointers back to requester 0 after reset
        @(negedge clk);
        wr_req = 2'b11; wa0 = 12'h040; wa1 = 12'h041; wd0 = 64'h40; wd1 = 64'h41;
        rd_req = 2'b11; ra0 = 12'h005; ra1 = 12'h010;
        #1;
        check("post-reset wr_gnt", 64'(wr_gnt), 64'h1);
        check("post-reset rd_gnt", 64'(rd_gnt), 64'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("post-reset ram_wr_add", 64'(ram_wr_add), 64'h040);
        check("post-reset ram_rd_add", 64'(ram_rd_add), 64'h005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dpram_access_arbiter.md
Name: dpram_access_arbiter

Overview:
- Shares the single write port and single read port of dual_port_ram between two write requesters and two read requesters.
- Arbitration is round-robin and independent per port.
- Registers all RAM-side controls and returns read data tagged with the requester ID.
- Sits between the agents/masters and dual_port_ram on the same clk domain.

Parameters:
ADDR_W, 12, RAM address width (matches wr_add/rd_add)
DATA_W, 64, RAM data width (matches in/out)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
wr_req  input  2  write request per requester [0],[1]
wr_addr  input  2*ADDR_W  write addresses, requester i at [i*ADDR_W +: ADDR_W]
wr_data  input  2*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
wr_gnt  output  2  one-hot write grant (combinational)
rd_req  input  2  read request per requester
rd_addr  input  2*ADDR_W  read addresses, same packing as wr_addr
rd_gnt  output  2  one-hot read grant (combinational)
rd_data  output  DATA_W  returned read data
rd_valid  output  1  rd_data valid this cycle
rd_id  output  1  requester index owning rd_data
ram_wr  output  1  to dual_port_ram wr (registered)
ram_wr_add  output  ADDR_W  to wr_add (registered)
ram_in  output  DATA_W  to in (registered)
ram_rd  output  1  to dual_port_ram rd (registered)
ram_rd_add  output  ADDR_W  to rd_add (registered)
ram_out  input  DATA_W  from dual_port_ram out

Behaviour:
- Async reset (rst_n low): ram_wr=0, ram_rd=0, ram_wr_add=0, ram_rd_add=0, ram_in=0, rd_valid=0, rd_id=0, rd_data=0, both priority pointers=0 (requester 0 favoured). Reset mid-operation drops in-flight reads; no rd_valid after release for pre-reset grants.
- RAM contract: dual_port_ram samples wr/rd/addresses at posedge; out is registered and valid in the cycle after the sampling edge.
- Handshake: requester holds req, addr and data stable until gnt is seen high at a posedge; the transfer completes on that edge. gnt is never high without the matching req.
- Arbitration (each port independently): one requester active -> it is granted every cycle. Both active -> grant the pointer's requester; after any grant the pointer moves to the other requester. No requester active -> no grant, pointer unchanged.
- Write path: grant in cycle N -> ram_wr=1 with the granted wr_add/in during N+1. ram_wr=0 in any cycle following a no-grant cycle. Sustained throughput is 1 write/cycle.
- Read path: grant in cycle N -> ram_rd=1 with ram_rd_add during N+1 -> RAM out valid in N+2 -> rd_valid=1, rd_id=granted index, rd_data=ram_out in N+2. Latency grant->data = 2 cycles. Back-to-back reads pipeline at 1/cycle. Order is preserved.
- rd_data holds its last value when rd_valid=0.
- Simultaneous read and write to the same address issued to the RAM in the same cycle (collision): without the optional feature, rd_data = ram_out (old RAM contents).
- Address/data widths pass through unmodified; no arithmetic on addresses.

Optional Feature:
- Macro RAW_BYPASS_EN.
- Defined: the collision condition (ram_wr && ram_rd && ram_wr_add==ram_rd_add in cycle N+1) is registered. In N+2, rd_data = the ram_in value written in N+1 instead of ram_out, giving read-after-write-coherent data. Adds one DATA_W register and one compare.
- Undefined: no compare logic; rd_data always = ram_out.

Test Plan:
- Reset then single write: wr_req=01, addr 0x005, data 0xA5A5 -> wr_gnt=01 same cycle; next cycle ram_wr=1, ram_wr_add=0x005, ram_in=0xA5A5.
- Contention: wr_req=11 held for 4 cycles -> wr_gnt sequence 01,10,01,10; RAM sees the writes in that order, one per cycle.
- Read latency: after writing 0x1234 to 0x010, rd_req=10 addr 0x010 -> rd_gnt=10 in N; rd_valid=1, rd_id=1, rd_data=0x1234 in N+2.
- Pipelined reads: rd_req=11 for 2 cycles -> rd_valid high for 2 consecutive cycles with rd_id 0 then 1, data matching each address.
- Collision at 0x020 (old value 0x1111, new 0x2222) issued the same cycle -> rd_data=0x1111 without RAW_BYPASS_EN, 0x2222 with it.
- Assert rst_n low in the cycle after a read grant -> outputs zero immediately; rd_valid stays 0 after release; pointers back to 0 (next contention grants requester 0 first).
